// File: rtl/dram_burst.sv
// rtl/dram_burst.sv - main-memory burst model with wrapping critical-word-first bursts.
// Define DRAM_BYTE_WRITE_EN to honour wstrb on write beats.
module dram_burst #(
  parameter int WORD_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 16,
  parameter int READ_LATENCY  = 8,
  parameter int WRITE_LATENCY = 6,
  parameter int CYCLE_TIME    = 2,
  parameter int BLOCK_SIZE    = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [WORD_WIDTH-1:0]   wdata,
  input  logic [WORD_WIDTH/8-1:0] wstrb,
  output logic                    wdata_ready,
  output logic [WORD_WIDTH-1:0]   rdata,
  output logic                    rdata_valid,
  output logic                    busy,
  output logic                    done
);

  localparam int BW   = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam int M1   = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int MAXV = (M1 > CYCLE_TIME) ? M1 : CYCLE_TIME;
  localparam int CW   = $clog2(MAXV + 1);
  localparam int NB   = WORD_WIDTH / 8;

  // Counters are loaded with N-2 because the cycle that leaves a state already counts as one.
  localparam logic [CW-1:0] RD_LOAD  = CW'((READ_LATENCY  > 1) ? READ_LATENCY  - 2 : 0);
  localparam logic [CW-1:0] WR_LOAD  = CW'((WRITE_LATENCY > 1) ? WRITE_LATENCY - 2 : 0);
  localparam logic [CW-1:0] GAP_LOAD = CW'((CYCLE_TIME    > 1) ? CYCLE_TIME    - 2 : 0);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BLOCK_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] OFS_MASK = ADDR_WIDTH'(BLOCK_SIZE - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, BEAT, GAP} state_t;

  state_t                  state;
  logic                    write_q;
  logic [ADDR_WIDTH-1:0]   base;
  logic [BW-1:0]           beat;
  logic [CW-1:0]           cnt;
  logic [WORD_WIDTH-1:0]   mem [0:(2**ADDR_WIDTH)-1];

  logic                    write_sel;
  logic [ADDR_WIDTH-1:0]   base_sel;
  logic                    enter_beat;
  logic [BW-1:0]           enter_idx;
  logic [ADDR_WIDTH-1:0]   enter_addr;
  logic [ADDR_WIDTH-1:0]   cur_addr;
  logic                    is_last;

  function automatic logic [ADDR_WIDTH-1:0] wrap_addr(input logic [ADDR_WIDTH-1:0] b,
                                                      input logic [BW-1:0] k);
    return (b & ~OFS_MASK) | ((b + ADDR_WIDTH'(k)) & OFS_MASK);
  endfunction

  assign write_sel = (state == IDLE) ? req_write : write_q;
  assign base_sel  = (state == IDLE) ? req_addr : base;
  assign is_last   = (beat == LAST_BEAT);
  assign cur_addr  = wrap_addr(base, beat);
  assign enter_addr = wrap_addr(base_sel, enter_idx);

  // Outputs are registered, so the beat is decided one cycle ahead of the cycle it shows on.
  always_comb begin
    enter_beat = 1'b0;
    enter_idx  = beat;
    case (state)
      IDLE: begin
        if (req_valid && ((req_write && WRITE_LATENCY == 1) || (!req_write && READ_LATENCY == 1))) begin
          enter_beat = 1'b1;
          enter_idx  = '0;
        end
      end
      ACCESS: enter_beat = (cnt == '0);
      BEAT: begin
        if (!is_last && CYCLE_TIME == 1) begin
          enter_beat = 1'b1;
          enter_idx  = beat + BW'(1);
        end
      end
      GAP: enter_beat = (cnt == '0);
      default: enter_beat = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      write_q     <= 1'b0;
      base        <= '0;
      beat        <= '0;
      cnt         <= '0;
      req_ready   <= 1'b1;
      wdata_ready <= 1'b0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      wdata_ready <= 1'b0;
      rdata_valid <= 1'b0;
      done        <= 1'b0;
      if (enter_beat) begin
        wdata_ready <= write_sel;
        rdata_valid <= !write_sel;
        done        <= (enter_idx == LAST_BEAT);
        if (!write_sel) rdata <= mem[enter_addr];
      end
      case (state)
        IDLE: begin
          if (req_valid) begin
            write_q   <= req_write;
            base      <= req_addr;
            beat      <= '0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (enter_beat) begin
              state <= BEAT;
            end else begin
              state <= ACCESS;
              cnt   <= req_write ? WR_LOAD : RD_LOAD;
            end
          end
        end
        ACCESS: begin
          if (cnt == '0) state <= BEAT;
          else cnt <= cnt - CW'(1);
        end
        BEAT: begin
          if (is_last) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            beat <= beat + BW'(1);
            if (CYCLE_TIME == 1) begin
              state <= BEAT;
            end else begin
              state <= GAP;
              cnt   <= GAP_LOAD;
            end
          end
        end
        GAP: begin
          if (cnt == '0) state <= BEAT;
          else cnt <= cnt - CW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The array is deliberately outside reset so contents survive a mid-burst reset.
  always_ff @(posedge clock) begin
    if (state == BEAT && write_q) begin
`ifdef DRAM_BYTE_WRITE_EN
      for (int i = 0; i < NB; i++) begin
        if (wstrb[i]) mem[cur_addr][8*i +: 8] <= wdata[8*i +: 8];
      end
`else
      mem[cur_addr] <= wdata;
`endif
    end
  end

`ifndef DRAM_BYTE_WRITE_EN
  logic unused_strb;
  assign unused_strb = ^wstrb;
`endif

endmodule

// File: tb/tb_dram_burst.sv
// tb/tb_dram_burst.sv - randomized self-checking bench for dram_burst against a burst-level memory model.
module tb_dram_burst;
  localparam int RL = 8, WL = 6, CY = 2, BS = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic req_valid = 0, req_write = 0, req_ready, wdata_ready, rdata_valid, busy, done;
  logic [15:0] req_addr = 0;
  logic [31:0] wdata = 0, rdata;
  logic [3:0]  wstrb = 4'hF;

  logic b_req_valid = 0, b_req_write = 0, b_req_ready, b_wdata_ready, b_rdata_valid, b_busy, b_done;
  logic [15:0] b_req_addr = 0;
  logic [31:0] b_wdata = 0, b_rdata;
  logic [3:0]  b_wstrb = 4'hF;

  dram_burst #(.WORD_WIDTH(32), .ADDR_WIDTH(16), .READ_LATENCY(RL), .WRITE_LATENCY(WL),
               .CYCLE_TIME(CY), .BLOCK_SIZE(BS)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .wdata(wdata), .wstrb(wstrb),
    .wdata_ready(wdata_ready), .rdata(rdata), .rdata_valid(rdata_valid), .busy(busy), .done(done));

  dram_burst #(.WORD_WIDTH(32), .ADDR_WIDTH(16), .READ_LATENCY(1), .WRITE_LATENCY(1),
               .CYCLE_TIME(1), .BLOCK_SIZE(1)) dut_min (
    .clock(clock), .reset(reset), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_write(b_req_write), .req_addr(b_req_addr), .wdata(b_wdata), .wstrb(b_wstrb),
    .wdata_ready(b_wdata_ready), .rdata(b_rdata), .rdata_valid(b_rdata_valid), .busy(b_busy), .done(b_done));

  int checks = 0;
  int fails = 0;
  logic [31:0] model [int];
  logic [31:0] wr_data [4];

  int beat_cyc [4];
  logic [31:0] beat_dat [4];
  int nb, done_cyc, busy_bad, spur, ready_bad;
  logic accept_ready, ready_after, busy_after, rvalid_after;
  logic [31:0] rdata_after;

  function automatic int wrap(input int base, input int k);
    return (base / BS) * BS + ((base % BS) + k) % BS;
  endfunction

  // Issues one burst at the current cycle (cycle 0) and records what the DUT did, relative to it.
  task automatic drive_burst(input bit w, input bit hold, input int addr);
    bit fin;
    nb = 0; done_cyc = -1; busy_bad = 0; spur = 0; ready_bad = 0; fin = 0;
    for (int k = 0; k < 4; k++) begin beat_cyc[k] = -1; beat_dat[k] = 'x; end
    accept_ready = req_ready;
    req_valid = 1'b1; req_write = w; req_addr = 16'(addr); wdata = 32'hDEADBEEF; wstrb = 4'hF;
    for (int c = 1; c < 200 && !fin; c++) begin
      @(posedge clock); #1;
      if (!hold) req_valid = 1'b0;
      if (busy !== 1'b1) busy_bad++;
      if (req_ready !== 1'b0) ready_bad++;
      if ((w ? rdata_valid : wdata_ready) === 1'b1) spur++;
      if ((w ? wdata_ready : rdata_valid) === 1'b1) begin
        if (nb < 4) begin
          beat_cyc[nb] = c;
          if (w) begin
            wdata = wr_data[nb];
            model[wrap(addr, nb)] = wr_data[nb];
          end else begin
            beat_dat[nb] = rdata;
          end
        end
        nb++;
      end
      if (done === 1'b1) begin done_cyc = c; fin = 1; end
    end
    @(posedge clock); #1;
    if (!hold) req_valid = 1'b0;
    ready_after = req_ready; busy_after = busy; rvalid_after = rdata_valid; rdata_after = rdata;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    checks++; if (wdata_ready !== 1'b0) begin fails++; $display("FAIL reset_wdata_ready got %b want 0", wdata_ready); end
    checks++; if (rdata_valid !== 1'b0) begin fails++; $display("FAIL reset_rdata_valid got %b want 0", rdata_valid); end
    checks++; if (rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata got %h want 0", rdata); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL reset_busy_done got %b%b want 00", busy, done); end
    checks++; if (b_req_ready !== 1'b1 || b_busy !== 1'b0) begin fails++; $display("FAIL reset_min got ready=%b busy=%b want 1 0", b_req_ready, b_busy); end
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_write_read_aligned;
    for (int k = 0; k < 4; k++) wr_data[k] = 32'hA0A0_0000 + k;
    drive_burst(1, 0, 'h10);
    checks++; if (accept_ready !== 1'b1) begin fails++; $display("FAIL wr_accept got %b want 1", accept_ready); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (beat_cyc[k] !== WL + k * CY) begin fails++; $display("FAIL wr_beat%0d_cycle got %0d want %0d", k, beat_cyc[k], WL + k * CY); end
    end
    checks++; if (nb !== 4) begin fails++; $display("FAIL wr_beat_count got %0d want 4", nb); end
    checks++; if (done_cyc !== WL + 3 * CY) begin fails++; $display("FAIL wr_done_cycle got %0d want %0d", done_cyc, WL + 3 * CY); end
    checks++; if (busy_bad !== 0 || spur !== 0 || ready_bad !== 0) begin fails++; $display("FAIL wr_flags got busy_bad=%0d spur=%0d ready_bad=%0d want 0", busy_bad, spur, ready_bad); end
    checks++; if (ready_after !== 1'b1 || busy_after !== 1'b0) begin fails++; $display("FAIL wr_after got ready=%b busy=%b want 1 0", ready_after, busy_after); end
    drive_burst(0, 0, 'h10);
    for (int k = 0; k < 4; k++) begin
      checks++; if (beat_cyc[k] !== RL + k * CY) begin fails++; $display("FAIL rd_beat%0d_cycle got %0d want %0d", k, beat_cyc[k], RL + k * CY); end
      checks++; if (beat_dat[k] !== 32'hA0A0_0000 + k) begin fails++; $display("FAIL rd_beat%0d_data got %h want %h", k, beat_dat[k], 32'hA0A0_0000 + k); end
    end
    checks++; if (done_cyc !== RL + 3 * CY) begin fails++; $display("FAIL rd_done_cycle got %0d want %0d", done_cyc, RL + 3 * CY); end
    checks++; if (rvalid_after !== 1'b0 || rdata_after !== 32'hA0A0_0003) begin fails++; $display("FAIL rd_hold got valid=%b data=%h want 0 a0a00003", rvalid_after, rdata_after); end
  endtask

  task automatic test_wrap;
    int order [4];
    order = '{'h12, 'h13, 'h10, 'h11};
    drive_burst(0, 0, 'h12);
    for (int k = 0; k < 4; k++) begin
      checks++; if (beat_dat[k] !== 32'hA0A0_0000 + (order[k] - 'h10)) begin fails++; $display("FAIL wrap_beat%0d got %h want %h", k, beat_dat[k], 32'hA0A0_0000 + (order[k] - 'h10)); end
    end
  endtask

  task automatic test_random;
    int blocks [$];
    int ra;
    for (int it = 0; it < 8; it++) begin
      ra = $urandom_range(0, 16'hFFFF);
      for (int k = 0; k < 4; k++) wr_data[k] = $urandom;
      drive_burst(1, 0, ra);
      blocks.push_back(ra);
      checks++; if (nb !== 4 || done_cyc !== WL + 3 * CY) begin fails++; $display("FAIL rnd_wr%0d got beats=%0d done=%0d want 4 %0d", it, nb, done_cyc, WL + 3 * CY); end
      ra = blocks[$urandom_range(0, blocks.size() - 1)];
      ra = (ra / BS) * BS + $urandom_range(0, BS - 1);
      drive_burst(0, 0, ra);
      for (int k = 0; k < 4; k++) begin
        checks++; if (beat_dat[k] !== model[wrap(ra, k)] || beat_cyc[k] !== RL + k * CY) begin
          fails++; $display("FAIL rnd_rd%0d_beat%0d addr %h got %h@%0d want %h@%0d", it, k, wrap(ra, k), beat_dat[k], beat_cyc[k], model[wrap(ra, k)], RL + k * CY);
        end
      end
    end
  endtask

  task automatic test_reset_mid_read;
    int bad;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h10;
    for (int c = 1; c <= RL + 2 * CY; c++) begin @(posedge clock); #1; req_valid = 1'b0; end
    checks++; if (rdata_valid !== 1'b1 || rdata !== model[wrap('h10, 2)]) begin fails++; $display("FAIL mid_beat2 got valid=%b data=%h want 1 %h", rdata_valid, rdata, model[wrap('h10, 2)]); end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    checks++; if (rdata_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 || done !== 1'b0 || rdata !== 32'h0) begin
      fails++; $display("FAIL mid_reset got valid=%b busy=%b ready=%b done=%b rdata=%h want 0 0 1 0 0", rdata_valid, busy, req_ready, done, rdata);
    end
    bad = 0;
    repeat (RL + 4 * CY) begin @(posedge clock); #1; if (done === 1'b1 || rdata_valid === 1'b1 || busy === 1'b1) bad++; end
    checks++; if (bad !== 0) begin fails++; $display("FAIL mid_quiet got %0d active cycles want 0", bad); end
    drive_burst(0, 0, 'h10);
    for (int k = 0; k < 4; k++) begin
      checks++; if (beat_dat[k] !== model[wrap('h10, k)]) begin fails++; $display("FAIL mid_reread_beat%0d got %h want %h", k, beat_dat[k], model[wrap('h10, k)]); end
    end
  endtask

  task automatic test_back_to_back;
    drive_burst(0, 1, 'h10);
    checks++; if (ready_bad !== 0) begin fails++; $display("FAIL b2b_ready_low got %0d high cycles want 0", ready_bad); end
    checks++; if (ready_after !== 1'b1) begin fails++; $display("FAIL b2b_ready_done1 got %b want 1", ready_after); end
    drive_burst(0, 0, 'h12);
    checks++; if (accept_ready !== 1'b1 || beat_cyc[0] !== RL) begin fails++; $display("FAIL b2b_second_accept got ready=%b beat0=%0d want 1 %0d", accept_ready, beat_cyc[0], RL); end
    checks++; if (beat_dat[0] !== model['h12] || done_cyc !== RL + 3 * CY) begin fails++; $display("FAIL b2b_second_data got %h done=%0d want %h %0d", beat_dat[0], done_cyc, model['h12], RL + 3 * CY); end
  endtask

  task automatic test_min_config;
    logic [31:0] data [3];
    logic [3:0]  strb [3];
    logic [31:0] exp;
    data = '{32'hFFFFFFFF, 32'h12345678, 32'h0};
    strb = '{4'hF, 4'b0101, 4'h0};
    for (int t = 0; t < 2; t++) begin
      b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = 16'h20; b_wdata = data[t]; b_wstrb = strb[t];
      @(posedge clock); #1;
      b_req_valid = 1'b0;
      checks++; if (b_wdata_ready !== 1'b1 || b_done !== 1'b1) begin fails++; $display("FAIL min_wr%0d got wready=%b done=%b want 1 1", t, b_wdata_ready, b_done); end
      @(posedge clock); #1;
      checks++; if (b_req_ready !== 1'b1 || b_busy !== 1'b0) begin fails++; $display("FAIL min_wr%0d_after got ready=%b busy=%b want 1 0", t, b_req_ready, b_busy); end
    end
`ifdef DRAM_BYTE_WRITE_EN
    exp = 32'hFF34FF78;
`else
    exp = 32'h12345678;
`endif
    b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 16'h20;
    @(posedge clock); #1;
    b_req_valid = 1'b0;
    checks++; if (b_rdata_valid !== 1'b1 || b_done !== 1'b1 || b_busy !== 1'b1) begin fails++; $display("FAIL min_rd_t1 got valid=%b done=%b busy=%b want 1 1 1", b_rdata_valid, b_done, b_busy); end
    checks++; if (b_rdata !== exp) begin fails++; $display("FAIL min_byte_mask got %h want %h", b_rdata, exp); end
    @(posedge clock); #1;
    checks++; if (b_req_ready !== 1'b1 || b_rdata_valid !== 1'b0 || b_done !== 1'b0) begin fails++; $display("FAIL min_rd_t2 got ready=%b valid=%b done=%b want 1 0 0", b_req_ready, b_rdata_valid, b_done); end
  endtask

  initial begin
    test_reset;
    test_write_read_aligned;
    test_wrap;
    test_random;
    test_reset_mid_read;
    test_back_to_back;
    test_min_config;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/dram_burst.md
# dram_burst

Parametrised main-memory bus model with programmable access latency, beat spacing and burst length. It replaces the shared-inout single-word DRAM model with separate read and write data paths and a valid/ready request handshake. Bursts use critical-word-first wrapping, and writes can optionally be byte-masked. It sits behind the cache refill/writeback path as the CPU's main memory.

## Interface
Parameters:
- WORD_WIDTH, 32, data word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 16, word address width; memory depth is 2**ADDR_WIDTH words.
- READ_LATENCY, 8, cycles from request acceptance to the first read beat; must be ≥1.
- WRITE_LATENCY, 6, cycles from request acceptance to the first write beat; must be ≥1.
- CYCLE_TIME, 2, cycles between consecutive beats; must be ≥1.
- BLOCK_SIZE, 4, beats per burst; must be a power of two, ≥1.

Ports:
- clock  in  1  clock, rising edge.
- reset  in  1  reset: synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = write burst, 0 = read burst.
- req_addr  in  ADDR_WIDTH  word address of the critical (first) beat.
- wdata  in  WORD_WIDTH  write beat data.
- wstrb  in  WORD_WIDTH/8  write byte enables.
- wdata_ready  out  1  the current write beat is sampled this cycle.
- rdata  out  WORD_WIDTH  read beat data, registered.
- rdata_valid  out  1  rdata holds a valid beat this cycle.
- busy  out  1  a burst is in progress.
- done  out  1  one-cycle pulse on the final beat of a burst.

## Operation
- State machine states: IDLE, ACCESS, BEAT, GAP.
- IDLE: req_ready=1. When req_valid && req_ready, latch req_write and req_addr, clear the beat counter, load the latency counter, and move to ACCESS.
- ACCESS: count down READ_LATENCY or WRITE_LATENCY, according to the latched req_write, then move to BEAT.
- BEAT: one beat transfers.
  - Read beat: rdata and rdata_valid are registered so that they are visible on the beat cycle.
  - Write beat: wdata_ready=1, and the array is written at the next edge.
  - On the last beat, done=1. The next state is IDLE if this is the last beat, GAP if CYCLE_TIME>1, otherwise BEAT again.
- GAP: wait CYCLE_TIME-1 cycles, then move to BEAT.
- Beat k address: {base[ADDR_WIDTH-1:log2(BLOCK_SIZE)], (base[log2(BLOCK_SIZE)-1:0]+k) mod BLOCK_SIZE}. The burst wraps inside its aligned block and never crosses a block boundary.
- Requests are not accepted while busy. req_valid is ignored outside IDLE, and no queueing occurs.
- The storage array is not reset. Contents survive reset; the array power-up value is X.
- Read-after-write: a read accepted after a write's done returns the written data.
- rdata holds the last beat value after the burst, with rdata_valid=0.

## Timing
- Reset values: req_ready=1, wdata_ready=0, rdata=0, rdata_valid=0, busy=0, done=0, state=IDLE.
- Reset mid-burst: on the next cycle the block is in IDLE with all outputs at reset values. No done pulse is issued, and already-written beats remain in memory.
- Request accepted at cycle T:
  - Read beat k: rdata_valid at T+READ_LATENCY+k*CYCLE_TIME.
  - Write beat k: wdata_ready at T+WRITE_LATENCY+k*CYCLE_TIME.
  - done: coincides with beat BLOCK_SIZE-1.
- busy is high from T+1 through the done cycle.
- req_ready returns to 1 on the cycle after done. The earliest next acceptance is done+1.
- CYCLE_TIME=1 gives back-to-back beats. BLOCK_SIZE=1 gives a single beat, with done on that beat.

## Configuration
- DRAM_BYTE_WRITE_EN defined: on each write beat, only bytes with wstrb[i]=1 are updated; the other bytes keep their old value.
- DRAM_BYTE_WRITE_EN undefined: wstrb is ignored and every write beat writes the full word.

## Test plan
Defaults apply unless noted.
- Write then read, aligned: write 0x10 with data A0..A3 (strb all 1), accepted at T. Required: wdata_ready at T+6, 8, 10, 12 and done at T+12. A read of 0x10 accepted at U returns rdata_valid at U+8, 10, 12, 14 with A0, A1, A2, A3.
- Wrap: a read accepted at 0x12 returns the words at 0x12, 0x13, 0x10, 0x11 in that order.
- Byte mask: with BLOCK_SIZE=1, write 0x20=0xFFFFFFFF, then write 0x20=0x12345678 with wstrb=4'b0101. A read returns 0xFF34FF78 with DRAM_BYTE_WRITE_EN defined, and 0x12345678 without it.
- Reset mid-read: assert reset on beat 2. Required next cycle: rdata_valid=0, busy=0, req_ready=1, and no done. A subsequent read returns the unchanged data.
- Busy back-pressure: hold req_valid high throughout a burst. Required: req_ready=0 until done+1, and the second request is accepted exactly at done+1.
- Minimum config: READ_LATENCY=1, CYCLE_TIME=1, BLOCK_SIZE=1. A read accepted at T gives rdata_valid and done both at T+1, and req_ready=1 at T+2.
